// File: rtl/mnist_pkg.sv
// Shared encodings and helpers for the MNIST frame controller.
// Latency: none (package). Backpressure: none (package).
package mnist_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int ERR_LEN = 0;
    localparam int ERR_TMO = 1;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_LOAD = ST_LOAD,
        S_WAIT = ST_WAIT,
        S_DONE = ST_DONE
    } state_t;

    function automatic int clog2(input int value);
        int r;
        int x;
        r = 0;
        x = value - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mnist_argmax_acc.sv
// Running signed argmax over a logit stream; ties keep the lower index.
// Latency: registered state updates 1 cycle after strobe; nxt_* give the post-strobe view combinationally.
// Backpressure: none, every strobe is consumed.
module mnist_argmax_acc
    import mnist_pkg::*;
#(
    parameter int LOGIT_W = 32,
    parameter int CLS_W   = 4,
    parameter int NC_W    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      strobe,
    input  logic signed [LOGIT_W-1:0] data,
    output logic        [CLS_W-1:0]   idx,
    output logic signed [LOGIT_W-1:0] max_logit,
    output logic        [NC_W-1:0]    count,
    output logic        [CLS_W-1:0]   nxt_idx,
    output logic signed [LOGIT_W-1:0] nxt_max
);

    logic take;

    // The first logit of a frame seeds the max regardless of its value.
    always_comb begin
        take    = (count == '0) | (data > max_logit);
        nxt_idx = take ? CLS_W'(count) : idx;
        nxt_max = take ? data : max_logit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            max_logit <= '0;
            count     <= '0;
        end else if (clear) begin
            idx       <= '0;
            max_logit <= '0;
            count     <= '0;
        end else if (strobe) begin
            idx       <= nxt_idx;
            max_logit <= nxt_max;
            count     <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mnist_frame_ctrl.sv
// Frame controller: pixel stream to core, logits to argmax result with length/timeout status.
// Latency: pixel to core_valid 1 cycle; final logit to m_valid 1 cycle.
// Backpressure: s_ready low outside IDLE/LOAD; result held until m_ready.
module mnist_frame_ctrl
    import mnist_pkg::*;
#(
    parameter int IMG_W       = 28,
    parameter int IMG_H       = 28,
    parameter int PIX_W       = 8,
    parameter int NUM_CLASSES = 10,
    parameter int LOGIT_W     = 32,
    parameter int TIMEOUT     = 65535,
    localparam int CLS_W      = (clog2(NUM_CLASSES) > 1) ? clog2(NUM_CLASSES) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic        [PIX_W-1:0]   s_data,
    input  logic                      s_last,
    output logic                      core_valid,
    output logic        [PIX_W-1:0]   core_pixel,
    input  logic                      core_res_valid,
    input  logic signed [LOGIT_W-1:0] core_res_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic        [CLS_W-1:0]   m_class,
    output logic        [LOGIT_W-1:0] m_score,
    output logic        [1:0]         m_err,
    output logic        [15:0]        frame_cnt,
    output logic                      busy
);

    localparam int N     = IMG_W * IMG_H;
    localparam int CNT_W = clog2(N + 1);
    localparam int NC_W  = clog2(NUM_CLASSES + 1);
    localparam int WD_W  = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(N - 1);
    localparam logic [NC_W-1:0]  CLS_LAST = NC_W'(NUM_CLASSES - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t                      state;
    logic        [CNT_W-1:0]     pix_cnt;
    logic        [WD_W-1:0]      wd_cnt;
    logic                        len_err;
    logic                        accept, frame_end, in_wait, acc_strobe, last_logit, wd_expire;
    logic        [1:0]           err_now;
    logic        [CLS_W-1:0]     acc_idx, nxt_idx;
    logic signed [LOGIT_W-1:0]   acc_max, nxt_max;
    logic        [NC_W-1:0]      acc_count;

    always_comb begin
        accept     = s_valid & s_ready;
        frame_end  = accept & (s_last | (pix_cnt == PIX_LAST));
        in_wait    = (state == S_WAIT);
        acc_strobe = in_wait & core_res_valid;
        last_logit = acc_strobe & (acc_count == CLS_LAST);
        // Idle cycle that would bring the watchdog up to TIMEOUT ends the wait.
        wd_expire  = (TIMEOUT > 0) & in_wait & ~core_res_valid & (wd_cnt == WD_LAST);
        err_now          = '0;
        err_now[ERR_LEN] = len_err;
        err_now[ERR_TMO] = wd_expire;
    end

    mnist_argmax_acc #(
        .LOGIT_W (LOGIT_W),
        .CLS_W   (CLS_W),
        .NC_W    (NC_W)
    ) u_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (~in_wait),
        .strobe    (acc_strobe),
        .data      (core_res_data),
        .idx       (acc_idx),
        .max_logit (acc_max),
        .count     (acc_count),
        .nxt_idx   (nxt_idx),
        .nxt_max   (nxt_max)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            s_ready    <= 1'b0;
            core_valid <= 1'b0;
            core_pixel <= '0;
            m_valid    <= 1'b0;
            m_class    <= '0;
            m_score    <= '0;
            m_err      <= '0;
            frame_cnt  <= '0;
            busy       <= 1'b0;
            pix_cnt    <= '0;
            wd_cnt     <= '0;
            len_err    <= 1'b0;
        end else begin
            core_valid <= accept;
            if (accept) core_pixel <= s_data;
            case (state)
                S_IDLE, S_LOAD: begin
                    s_ready <= ~frame_end;
                    if (accept) begin
                        busy <= 1'b1;
                        if (frame_end) begin
                            state   <= S_WAIT;
                            pix_cnt <= '0;
                            wd_cnt  <= '0;
                            len_err <= s_last ^ (pix_cnt == PIX_LAST);
                        end else begin
                            state   <= S_LOAD;
                            pix_cnt <= pix_cnt + 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (acc_strobe) wd_cnt <= '0;
                    else if (TIMEOUT > 0) wd_cnt <= wd_cnt + 1'b1;
                    if (last_logit | wd_expire) begin
                        state   <= S_DONE;
                        m_valid <= 1'b1;
                        m_class <= last_logit ? nxt_idx : acc_idx;
                        m_score <= last_logit ? nxt_max : acc_max;
                        m_err   <= err_now;
                    end
                end
                S_DONE: begin
                    if (m_ready) begin
                        m_valid   <= 1'b0;
                        frame_cnt <= frame_cnt + 1'b1;
                        state     <= S_IDLE;
                        s_ready   <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mnist_frame_ctrl.sv
// Directed bench for mnist_frame_ctrl with a frame-level argmax model and per-cycle pixel checks.
module tb_mnist_frame_ctrl;

    localparam int N    = 784;
    localparam int NCLS = 10;
    localparam int TMO  = 16;

    typedef logic signed [31:0] lq_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = '0;
    logic        s_last = 1'b0;
    logic        core_valid;
    logic [7:0]  core_pixel;
    logic        core_res_valid = 1'b0;
    logic signed [31:0] core_res_data = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [3:0]  m_class;
    logic [31:0] m_score;
    logic [1:0]  m_err;
    logic [15:0] frame_cnt;
    logic        busy;

    int n_chk = 0;
    int n_pass = 0;
    int fc_model = 0;
    int pulse_cnt = 0;
    logic       exp_cv;
    logic [7:0] exp_px;
    int          got_cls;
    logic [31:0] got_sc;
    logic [1:0]  got_err;

    mnist_frame_ctrl #(
        .IMG_W(28), .IMG_H(28), .PIX_W(8), .NUM_CLASSES(NCLS), .LOGIT_W(32), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .core_valid(core_valid), .core_pixel(core_pixel),
        .core_res_valid(core_res_valid), .core_res_data(core_res_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_class(m_class), .m_score(m_score),
        .m_err(m_err), .frame_cnt(frame_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    function automatic void model(input lq_t q, output int cls, output logic signed [31:0] sc);
        cls = 0;
        sc  = 0;
        for (int i = 0; i < q.size(); i++)
            if (i == 0 || q[i] > sc) begin
                cls = i;
                sc  = q[i];
            end
    endfunction

    // Every accepted beat must appear on the core port exactly one cycle later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_cv <= 1'b0;
            exp_px <= '0;
        end else begin
            exp_cv <= s_valid && s_ready;
            exp_px <= s_data;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_core_valid", core_valid, 0);
            chk("rst_m_valid", m_valid, 0);
        end else begin
            chk("core_valid", core_valid, exp_cv);
            if (exp_cv) chk("core_pixel", core_pixel, exp_px);
            if (m_valid) chk("s_ready_in_done", s_ready, 0);
            if (core_valid) pulse_cnt++;
        end
    end

    task automatic send_frame(input int npix, input int last_at, input bit gaps);
        bit ok;
        for (int i = 0; i < npix; i++) begin
            if (gaps && $urandom_range(1, 0) == 1) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
            end
            s_valid = 1'b1;
            s_data  = 8'($urandom_range(255, 0));
            s_last  = (i == last_at);
            ok = 1'b0;
            for (int t = 0; t < 50; t++) begin
                @(negedge clk);
                if (s_ready) begin
                    ok = 1'b1;
                    @(posedge clk); #1;
                    break;
                end
                @(posedge clk); #1;
            end
            chk("pixel_accepted", ok, 1);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_logits(input lq_t q);
        for (int i = 0; i < q.size(); i++) begin
            core_res_valid = 1'b1;
            core_res_data  = q[i];
            @(posedge clk); #1;
            core_res_valid = 1'b0;
            if (i != q.size() - 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic do_frame(input string tag, input int npix, input int last_at,
                            input bit gaps, input lq_t q, input int hold);
        int exp_cls;
        logic signed [31:0] exp_sc;
        logic [1:0] exp_err;
        int lat;
        bit ok;
        model(q, exp_cls, exp_sc);
        exp_err[0] = !(npix == N && last_at == N - 1);
        exp_err[1] = (q.size() < NCLS);
        pulse_cnt = 0;
        send_frame(npix, last_at, gaps);
        send_logits(q);
        lat = 1;
        ok  = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (m_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_result_seen"}, ok, 1);
        chk({tag, "_latency"}, lat, exp_err[1] ? TMO + 1 : 1);
        chk({tag, "_class"}, m_class, exp_cls);
        chk({tag, "_score"}, m_score, exp_sc);
        chk({tag, "_err"}, m_err, exp_err);
        chk({tag, "_frame_cnt_pre"}, frame_cnt, fc_model);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_pulses"}, pulse_cnt, npix);
        got_cls = m_class;
        got_sc  = m_score;
        got_err = m_err;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            s_valid        = 1'b1;
            s_data         = 8'hA5;
            core_res_valid = h[0];
            core_res_data  = 32'sh7fffffff;
            @(negedge clk);
            chk({tag, "_hold_valid"}, m_valid, 1);
            chk({tag, "_hold_class"}, m_class, exp_cls);
            chk({tag, "_hold_score"}, m_score, exp_sc);
            chk({tag, "_hold_err"}, m_err, exp_err);
            chk({tag, "_hold_s_ready"}, s_ready, 0);
            chk({tag, "_hold_core_valid"}, core_valid, 0);
        end
        s_valid        = 1'b0;
        core_res_valid = 1'b0;
        m_ready        = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        fc_model++;
        @(negedge clk);
        chk({tag, "_m_valid_clear"}, m_valid, 0);
        chk({tag, "_s_ready_after"}, s_ready, 1);
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_frame_cnt_post"}, frame_cnt, fc_model);
        @(posedge clk); #1;
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        lq_t q;
        repeat (3) @(negedge clk);
        chk("reset_s_ready", s_ready, 0);
        chk("reset_busy", busy, 0);
        chk("reset_frame_cnt", frame_cnt, 0);
        chk("reset_m_class", m_class, 0);
        chk("reset_m_score", m_score, 0);
        chk("reset_m_err", m_err, 0);
        chk("reset_core_pixel", core_pixel, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        q = '{32'sd5, -32'sd3, 32'sd40, 32'sd40, 32'sd7, 32'sd0, 32'sd0, 32'sd0, 32'sd0, -32'sd1};
        do_frame("full", N, N - 1, 1'b0, q, 0);
        chk("lit_full_class", got_cls, 2);
        chk("lit_full_score", got_sc, 40);
        chk("lit_full_frame_cnt", frame_cnt, 1);

        q = '{-32'sd50, -32'sd40, -32'sd30, -32'sd20, -32'sd60, -32'sd70, -32'sd80, -32'sd90, -32'sd15, -32'sd5};
        do_frame("short", 501, 500, 1'b0, q, 50);
        chk("lit_short_class", got_cls, 9);
        chk("lit_short_err", got_err, 2'b01);

        q = '{32'sd3, 32'sd11, -32'sd2};
        do_frame("tmo", N, N - 1, 1'b0, q, 0);
        chk("lit_tmo_class", got_cls, 1);
        chk("lit_tmo_score", got_sc, 11);
        chk("lit_tmo_err", got_err, 2'b10);

        q = '{32'sh80000000, 32'sh7fffffff, 32'sh7fffffff, 32'sd0, 32'sd0,
              32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sh80000000};
        do_frame("nolast", N, -1, 1'b0, q, 0);
        chk("lit_nolast_class", got_cls, 1);
        chk("lit_nolast_err", got_err, 2'b01);

        q = {};
        do_frame("nologit", N, N - 1, 1'b0, q, 0);
        chk("lit_nologit_score", got_sc, 0);

        send_frame(300, -1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_s_ready", s_ready, 0);
        chk("arst_core_valid", core_valid, 0);
        chk("arst_core_pixel", core_pixel, 0);
        chk("arst_m_valid", m_valid, 0);
        chk("arst_m_class", m_class, 0);
        chk("arst_m_score", m_score, 0);
        chk("arst_m_err", m_err, 0);
        chk("arst_frame_cnt", frame_cnt, 0);
        chk("arst_busy", busy, 0);
        fc_model = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NCLS; i++) q.push_back(32'($urandom));
        do_frame("gaps", N, N - 1, 1'b1, q, 0);
        chk("lit_gaps_frame_cnt", frame_cnt, 1);

        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
